// File: rtl/llc_arb_pkg.sv
// llc_arb_pkg: FSM state and grant-owner encodings shared by llc_arbiter and llc_arb_rr.
package llc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_e;

endpackage

// File: rtl/llc_arb_rr.sv
// llc_arb_rr: 2-way L1D/L1I pick with a last-granted pointer. Ties alternate by default;
// build with LLC_ARB_D_PRIO_EN defined to give L1D fixed priority on ties instead.
module llc_arb_rr
    import llc_arb_pkg::*;
(
    input  logic clk_in,
    input  logic rst_N_in,
    input  logic req_d_i,
    input  logic req_i_i,
    input  logic advance_i,
    output logic gnt_d_o,
    output logic gnt_i_o
);

    owner_e last_q, last_d;

    always_comb begin
`ifdef LLC_ARB_D_PRIO_EN
        gnt_d_o = req_d_i;
`else
        gnt_d_o = req_d_i && (!req_i_i || (last_q == OWN_I));
`endif
        gnt_i_o = req_i_i && !gnt_d_o;
        last_d  = last_q;
        if (advance_i && gnt_d_o) begin
            last_d = OWN_D;
        end else if (advance_i && gnt_i_o) begin
            last_d = OWN_I;
        end
    end

    // Pointer starts at OWN_I so L1D takes the first tie after reset.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            last_q <= OWN_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/llc_arbiter.sv
// llc_arbiter: arbitrates L1D (read/writeback) and L1I (read) onto a single LLC port,
// one outstanding transaction at a time. Tie policy set by LLC_ARB_D_PRIO_EN (see llc_arb_rr).
module llc_arbiter
    import llc_arb_pkg::*;
#(
    parameter int PADDR_BITS = 19,
    parameter int B          = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    // L1D request / response
    input  logic                  d_valid_in,
    output logic                  d_ready_out,
    input  logic [PADDR_BITS-1:0] d_addr_in,
    input  logic [8*B-1:0]        d_line_in,
    input  logic                  d_we_in,
    output logic                  d_valid_out,
    input  logic                  d_ready_in,
    output logic [PADDR_BITS-1:0] d_addr_out,
    output logic [8*B-1:0]        d_line_out,
    // L1I request / response
    input  logic                  i_valid_in,
    output logic                  i_ready_out,
    input  logic [PADDR_BITS-1:0] i_addr_in,
    output logic                  i_valid_out,
    input  logic                  i_ready_in,
    output logic [PADDR_BITS-1:0] i_addr_out,
    output logic [8*B-1:0]        i_line_out,
    // LLC request / response
    output logic                  llc_valid_out,
    input  logic                  llc_ready_in,
    output logic [PADDR_BITS-1:0] llc_addr_out,
    output logic [8*B-1:0]        llc_line_out,
    output logic                  llc_we_out,
    input  logic                  llc_valid_in,
    output logic                  llc_ready_out,
    input  logic [PADDR_BITS-1:0] llc_addr_in,
    input  logic [8*B-1:0]        llc_line_in,
    output logic                  owner_out
);

    localparam int LW = 8 * B;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [PADDR_BITS-1:0] addr_q, addr_d;
    logic [LW-1:0]         line_q, line_d;
    logic                  we_q, we_d;
    logic [PADDR_BITS-1:0] raddr_q, raddr_d;
    logic [LW-1:0]         rline_q, rline_d;

    logic arb_en, gnt_d, gnt_i, up_xfer, owner_rdy;

    // Gating with rst_N_in keeps both readies low while reset is held.
    assign arb_en  = (state_q == ST_IDLE) && rst_N_in;
    assign up_xfer = gnt_d || gnt_i;

    llc_arb_rr u_rr (
        .clk_in    (clk_in),
        .rst_N_in  (rst_N_in),
        .req_d_i   (d_valid_in && arb_en),
        .req_i_i   (i_valid_in && arb_en),
        .advance_i (up_xfer),
        .gnt_d_o   (gnt_d),
        .gnt_i_o   (gnt_i)
    );

    assign owner_rdy = (owner_q == OWN_D) ? d_ready_in : i_ready_in;

    // NOTE: every _d gets its hold value before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        line_d  = line_q;
        we_d    = we_q;
        raddr_d = raddr_q;
        rline_d = rline_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_d) begin
                    owner_d = OWN_D;
                    addr_d  = d_addr_in;
                    line_d  = d_line_in;
                    we_d    = d_we_in;
                    state_d = ST_ISSUE;
                end else if (gnt_i) begin
                    owner_d = OWN_I;
                    addr_d  = i_addr_in;
                    line_d  = '0;
                    we_d    = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (llc_ready_in) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (llc_valid_in) begin
                    raddr_d = llc_addr_in;
                    rline_d = llc_line_in;
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (owner_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    // NOTE: the wide line registers are reset too, because the line outputs must read zero in reset.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_D;
            addr_q  <= '0;
            line_q  <= '0;
            we_q    <= 1'b0;
            raddr_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            we_q    <= we_d;
            raddr_q <= raddr_d;
            rline_q <= rline_d;
        end
    end

    assign d_ready_out   = gnt_d;
    assign i_ready_out   = gnt_i;
    assign llc_valid_out = (state_q == ST_ISSUE);
    assign llc_ready_out = (state_q == ST_WAIT);
    assign llc_addr_out  = addr_q;
    assign llc_line_out  = line_q;
    assign llc_we_out    = we_q;
    assign d_valid_out   = (state_q == ST_DELIVER) && (owner_q == OWN_D);
    assign i_valid_out   = (state_q == ST_DELIVER) && (owner_q == OWN_I);
    assign d_addr_out    = raddr_q;
    assign d_line_out    = rline_q;
    assign i_addr_out    = raddr_q;
    assign i_line_out    = rline_q;
    assign owner_out     = owner_q;

endmodule
